// File: rtl/data_mem_resp_pkg.sv
// Shared instruction definitions for the data-memory responder: op types,
// responder FSM states and fault classification.
package data_mem_resp_pkg;

    typedef enum logic [1:0] {
        OP_LW = 2'd0,
        OP_SW = 2'd1
    } op_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_t;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    // Misalignment wins over range so a bad low address is always reported as such.
    function automatic fault_t classify(input logic [31:0] addr, input int unsigned depth);
        if (addr[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if ({2'b00, addr[31:2]} >= depth) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/data_mem_resp_dmem_array.sv
// Single-port word storage: synchronous write, registered read, no reset so
// contents survive a responder reset.
module dmem_array #(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    always_comb begin
        rdata_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one load/store, inserts WAIT_CYCLES wait
// states, then holds the response until the core consumes it.
import data_mem_resp_pkg::*;

module data_mem_resp #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1. req_ready is 1 only in IDLE; resp_valid/rdata/err hold steady in
    // RESP until resp_ready is seen, and nothing is queued while busy.

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_type_t        op_q, op_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    fault_t          fault_q, fault_d;

    fault_t          fault_now;
    logic            arr_en;
    logic            arr_we;
    logic [31:0]     arr_rdata;

    assign fault_now = classify(addr_q, DEPTH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        arr_en  = 1'b0;
        arr_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    op_d    = req_we ? OP_SW : OP_LW;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Storage is touched only on this edge, so a reset in WAIT cancels the store.
                    state_d = ST_RESP;
                    fault_d = fault_now;
                    arr_en  = (fault_now == FAULT_NONE);
                    arr_we  = (fault_now == FAULT_NONE) && (op_q == OP_SW);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    fault_d = FAULT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fault_d = FAULT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_dmem_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = (fault_q != FAULT_NONE);
    // The array's read register is only meaningful for a good load in RESP.
    assign resp_rdata = (resp_valid && (op_q == OP_LW) && (fault_q == FAULT_NONE)) ? arr_rdata : '0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a WAIT_CYCLES=2 instance for the main
// sequence and a WAIT_CYCLES=0 instance for back-to-back spacing.
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A: WAIT_CYCLES=2 ----------------
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic [1:0]  a_dbg_state;

  data_mem_resp #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_we     (a_req_we),
    .req_addr   (a_req_addr),
    .req_wdata  (a_req_wdata),
    .resp_valid (a_resp_valid),
    .resp_ready (a_resp_ready),
    .resp_rdata (a_resp_rdata),
    .resp_err   (a_resp_err),
    .dbg_state  (a_dbg_state)
  );

  // ---------------- DUT B: WAIT_CYCLES=0 ----------------
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [1:0]  b_dbg_state;

  data_mem_resp #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_we     (b_req_we),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_rdata (b_resp_rdata),
    .resp_err   (b_resp_err),
    .dbg_state  (b_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks (DUT A) ----------------
  task automatic a_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag);
    int n;
    chk({tag, "_req_ready"}, 32'(a_req_ready), 32'd1);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    tick();
    a_req_valid = 1'b0;
    a_req_we    = 1'($urandom_range(0, 1));
    a_req_addr  = $urandom;
    a_req_wdata = $urandom;
    n = 0;
    while (!a_resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
  endtask

  task automatic a_release(input string tag);
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(a_resp_valid), 32'd0);
    chk({tag, "_rel_ready"}, 32'(a_req_ready), 32'd1);
    chk({tag, "_rel_rdata"}, a_resp_rdata, 32'd0);
  endtask

  task automatic a_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    a_issue(we, addr, wdata, tag);
    chk({tag, "_rdata"}, a_resp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(a_resp_err), 32'(exp_err));
    a_release(tag);
  endtask

  // ---------------- DUT B stimulus table ----------------
  logic        bv_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] bv_addr [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
  logic [31:0] bv_wdata[4] = '{32'h11111111, 32'h22222222, 32'h0, 32'h0};
  logic [31:0] bv_exp  [4] = '{32'h0, 32'h0, 32'h11111111, 32'h22222222};

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ri;
    int si;
    int acc_cyc;
    logic acc;

    rst          = 1'b0;
    a_req_valid  = 1'b0;
    a_req_we     = 1'b0;
    a_req_addr   = '0;
    a_req_wdata  = '0;
    a_resp_ready = 1'b0;
    b_req_valid  = 1'b0;
    b_req_we     = 1'b0;
    b_req_addr   = '0;
    b_req_wdata  = '0;
    b_resp_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_resp_rdata", a_resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(a_resp_err), 32'd0);
    chk("rst_state", 32'(a_dbg_state), 32'(ST_IDLE));
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_req_ready", 32'(a_req_ready), 32'd1);

    // Store then load same word
    a_access(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st10");
    a_access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld10");

    // Faults: misaligned and one past the last word
    a_access(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "ld13_misalign");
    a_access(1'b0, 32'h400, 32'h0, 32'h0, 1'b1, "ld400_range");
    a_access(1'b1, 32'h402, 32'hFFFFFFFF, 32'h0, 1'b1, "st402_fault");
    a_access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld10_after_fault");

    // Last valid word
    a_access(1'b1, 32'h3FC, 32'hA5A50001, 32'h0, 1'b0, "st3fc");
    a_access(1'b0, 32'h3FC, 32'h0, 32'hA5A50001, 1'b0, "ld3fc");

    // Back-pressure: response held, new request ignored
    a_issue(1'b0, 32'h10, 32'h0, "hold");
    for (int i = 0; i < 5; i++) begin
      a_req_valid = 1'b1;
      a_req_we    = 1'b1;
      a_req_addr  = 32'h10;
      a_req_wdata = 32'hBAD0BAD0;
      chk("hold_valid", 32'(a_resp_valid), 32'd1);
      chk("hold_rdata", a_resp_rdata, 32'hDEADBEEF);
      chk("hold_err", 32'(a_resp_err), 32'd0);
      chk("hold_req_ready", 32'(a_req_ready), 32'd0);
      tick();
    end
    a_req_valid = 1'b0;
    chk("hold_still_valid", 32'(a_resp_valid), 32'd1);
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    chk("hold_rel_valid", 32'(a_resp_valid), 32'd0);
    chk("hold_rel_state", 32'(a_dbg_state), 32'(ST_IDLE));
    chk("hold_rel_err", 32'(a_resp_err), 32'd0);
    a_access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld10_after_hold");

    // Reset mid-WAIT aborts a pending store
    a_access(1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "st20_pre");
    chk("abort_req_ready", 32'(a_req_ready), 32'd1);
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_addr  = 32'h20;
    a_req_wdata = 32'h12345678;
    tick();
    a_req_valid = 1'b0;
    chk("abort_in_wait", 32'(a_dbg_state), 32'(ST_WAIT));
    tick();
    rst = 1'b0;
    #1;
    chk("abort_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("abort_state", 32'(a_dbg_state), 32'(ST_IDLE));
    chk("abort_req_ready", 32'(a_req_ready), 32'd1);
    chk("abort_rdata", a_resp_rdata, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_resp", 32'(a_resp_valid), 32'd0);
      tick();
    end
    a_access(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "ld20_after_rst");
    a_access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld10_after_rst");

    // WAIT_CYCLES=0 instance: back-to-back with resp_ready held high
    chk("b_idle", 32'(b_req_ready), 32'd1);
    b_resp_ready = 1'b1;
    b_req_valid  = 1'b1;
    b_req_we     = bv_we[0];
    b_req_addr   = bv_addr[0];
    b_req_wdata  = bv_wdata[0];
    ri = 0;
    si = 0;
    acc_cyc = -100;
    for (int c = 0; c < 40 && si < 4; c++) begin
      acc = b_req_valid && b_req_ready;
      tick();
      if (acc) begin
        if (ri > 0) chk("b_accept_spacing", 32'(c - acc_cyc), 32'd3);
        acc_cyc = c;
        ri++;
        if (ri < 4) begin
          b_req_we    = bv_we[ri];
          b_req_addr  = bv_addr[ri];
          b_req_wdata = bv_wdata[ri];
        end else begin
          b_req_valid = 1'b0;
        end
      end
      if (b_resp_valid) begin
        chk("b_latency", 32'(c - acc_cyc), 32'd1);
        chk("b_rdata", b_resp_rdata, bv_exp[si]);
        chk("b_err", 32'(b_resp_err), 32'd0);
        si++;
      end
    end
    chk("b_responses_seen", 32'(si), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
